// File: rtl/fft_engine.sv
// 64-point radix-2 DIT FFT/IFFT: inputs loaded in bit-reversed order, one full
// stage of 32 butterflies per clock, 1/2 scaling per stage, natural-order output.
module fft_engine (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        ifft,
   input  logic [15:0] input_Re  [63:0],
   input  logic [15:0] input_Im  [63:0],
   output logic [15:0] output_Re [63:0],
   output logic [15:0] output_Im [63:0],
   output logic        state_dbg,
   output logic [2:0]  stage_dbg
);

   typedef enum logic {IDLE = 1'b0, COMPUTE = 1'b1} state_t;

   state_t      state;
   logic [2:0]  stage;
   logic        ifft_q;
   logic [15:0] w_re   [63:0];
   logic [15:0] w_im   [63:0];
   logic [15:0] nxt_re [63:0];
   logic [15:0] nxt_im [63:0];
   logic [5:0]  top_idx [32];
   logic [5:0]  bot_idx [32];
   logic [4:0]  tw_idx  [32];
   logic [15:0] top_re [32];
   logic [15:0] top_im [32];
   logic [15:0] bot_re [32];
   logic [15:0] bot_im [32];

   assign state_dbg = state;
   assign stage_dbg = stage;

   function automatic logic [5:0] bitrev6(input logic [5:0] v);
      logic [5:0] r;
      for (int b = 0; b < 6; b++) r[b] = v[5-b];
      return r;
   endfunction

   // round(32767*cos(2*pi*k/64)) for the first quadrant, k = 0..16
   function automatic logic signed [15:0] cos_mag(input logic [4:0] k);
      case (k)
         5'd0:    return 16'sd32767;
         5'd1:    return 16'sd32609;
         5'd2:    return 16'sd32137;
         5'd3:    return 16'sd31356;
         5'd4:    return 16'sd30273;
         5'd5:    return 16'sd28898;
         5'd6:    return 16'sd27245;
         5'd7:    return 16'sd25329;
         5'd8:    return 16'sd23170;
         5'd9:    return 16'sd20787;
         5'd10:   return 16'sd18204;
         5'd11:   return 16'sd15446;
         5'd12:   return 16'sd12539;
         5'd13:   return 16'sd9512;
         5'd14:   return 16'sd6393;
         5'd15:   return 16'sd3212;
         default: return 16'sd0;
      endcase
   endfunction

   function automatic logic signed [15:0] tw_re(input logic [4:0] t);
      if (t <= 5'd16) return cos_mag(t);
      else            return -cos_mag(5'(6'd32 - {1'b0, t}));
   endfunction

   // -sin(2*pi*t/64) equals -cos of the mirrored angle about t = 16
   function automatic logic signed [15:0] tw_im(input logic [4:0] t);
      if (t <= 5'd16) return -cos_mag(5'd16 - t);
      else            return -cos_mag(t - 5'd16);
   endfunction

   always_comb begin
      for (int k = 0; k < 32; k++) begin
         top_idx[k] = 6'(((k >> stage) << (stage + 3'd1)) | (k & ((1 << stage) - 1)));
         bot_idx[k] = top_idx[k] + 6'(1 << stage);
         tw_idx[k]  = 5'((k & ((1 << stage) - 1)) << (3'd5 - stage));
      end
   end

   for (genvar g = 0; g < 32; g++) begin : g_bfly
      logic signed [15:0] a_re, a_im, b_re, b_im, c_re, c_im;
      logic signed [31:0] m_rr, m_ii, m_ri, m_ir;
      logic signed [32:0] sum_re, sum_im;
      logic signed [17:0] p_re, p_im, add_re, add_im, sub_re, sub_im;

      always_comb begin
         a_re   = w_re[top_idx[g]];
         a_im   = w_im[top_idx[g]];
         b_re   = w_re[bot_idx[g]];
         b_im   = w_im[bot_idx[g]];
         c_re   = tw_re(tw_idx[g]);
         c_im   = ifft_q ? -tw_im(tw_idx[g]) : tw_im(tw_idx[g]);
         m_rr   = b_re * c_re;
         m_ii   = b_im * c_im;
         m_ri   = b_re * c_im;
         m_ir   = b_im * c_re;
         sum_re = 33'(m_rr) - 33'(m_ii);
         sum_im = 33'(m_ri) + 33'(m_ir);
         // The unity twiddle passes b through untouched so that DC and
         // impulse inputs transform without the 32767/32768 droop.
         if (tw_idx[g] == 5'd0) begin
            p_re = 18'(b_re);
            p_im = 18'(b_im);
         end else begin
            p_re = 18'(sum_re >>> 15);
            p_im = 18'(sum_im >>> 15);
         end
         add_re = 18'(a_re) + p_re;
         add_im = 18'(a_im) + p_im;
         sub_re = 18'(a_re) - p_re;
         sub_im = 18'(a_im) - p_im;
      end

      assign top_re[g] = 16'(add_re >>> 1);
      assign top_im[g] = 16'(add_im >>> 1);
      assign bot_re[g] = 16'(sub_re >>> 1);
      assign bot_im[g] = 16'(sub_im >>> 1);
   end

   always_comb begin
      nxt_re = w_re;
      nxt_im = w_im;
      for (int k = 0; k < 32; k++) begin
         nxt_re[top_idx[k]] = top_re[k];
         nxt_im[top_idx[k]] = top_im[k];
         nxt_re[bot_idx[k]] = bot_re[k];
         nxt_im[bot_idx[k]] = bot_im[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         stage  <= 3'd0;
         ifft_q <= 1'b0;
         for (int i = 0; i < 64; i++) begin
            w_re[i]      <= 16'h0000;
            w_im[i]      <= 16'h0000;
            output_Re[i] <= 16'h0000;
            output_Im[i] <= 16'h0000;
         end
      end else if (state == IDLE) begin
         if (start) begin
            for (int i = 0; i < 64; i++) begin
               w_re[bitrev6(6'(i))] <= input_Re[i];
               w_im[bitrev6(6'(i))] <= input_Im[i];
            end
            ifft_q <= ifft;
            stage  <= 3'd0;
            state  <= COMPUTE;
         end
      end else begin
         w_re <= nxt_re;
         w_im <= nxt_im;
         if (stage == 3'd5) begin
            output_Re <= nxt_re;
            output_Im <= nxt_im;
            stage     <= 3'd0;
            state     <= IDLE;
         end else begin
            stage <= stage + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_fft_engine.sv
// Directed bench for fft_engine: table of single-bin vectors plus hand-written
// sequences for hold, busy, back-to-back and reset-abort behaviour.
module tb_fft_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        ifft;
   logic [15:0] in_re  [63:0];
   logic [15:0] in_im  [63:0];
   logic [15:0] out_re [63:0];
   logic [15:0] out_im [63:0];
   logic        state_dbg;
   logic [2:0]  stage_dbg;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   typedef struct {
      string      name;
      logic       inv;
      logic       dc;
      int         pos;
      int         amp;
      int         k;
      int         exp_re;
      int         exp_im;
      int         tol;
   } vec_t;

   vec_t vecs [13];

   fft_engine dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ifft      (ifft),
      .input_Re  (in_re),
      .input_Im  (in_im),
      .output_Re (out_re),
      .output_Im (out_im),
      .state_dbg (state_dbg),
      .stage_dbg (stage_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic check_tol(input string name, input int act, input int req, input int tol);
      checks++;
      if (act - req > tol || req - act > tol) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d tol=%0d", name, act, req, tol);
      end
   endtask

   function automatic int bad_words(input int er, input int ei);
      int n = 0;
      for (int i = 0; i < 64; i++)
         if (out_re[i] != 16'(er) || out_im[i] != 16'(ei)) n++;
      return n;
   endfunction

   task automatic drive(input logic inv, input logic dc, input int pos, input int amp);
      for (int i = 0; i < 64; i++) begin
         in_re[i] = (dc || i == pos) ? 16'(amp) : 16'h0000;
         in_im[i] = 16'h0000;
      end
      ifft = inv;
   endtask

   task automatic scramble();
      for (int i = 0; i < 64; i++) begin
         in_re[i] = 16'($urandom_range(0, 65535));
         in_im[i] = 16'($urandom_range(0, 65535));
      end
      ifft = 1'($urandom_range(0, 1));
   endtask

   // Leaves the caller just after E6 with the result on the outputs.
   task automatic run(input logic inv, input logic dc, input int pos, input int amp);
      @(negedge clk);
      drive(inv, dc, pos, amp);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble();
      repeat (6) @(negedge clk);
   endtask

   initial begin
      vecs[0]  = '{"dc_x0",    1'b0, 1'b1, -1, 16'h0200,  0,  512,    0, 0};
      vecs[1]  = '{"dc_x1",    1'b0, 1'b1, -1, 16'h0200,  1,    0,    0, 0};
      vecs[2]  = '{"dc_x63",   1'b0, 1'b1, -1, 16'h0200, 63,    0,    0, 0};
      vecs[3]  = '{"sh_x0",    1'b0, 1'b0,  1, 16'h4000,  0,  256,    0, 2};
      vecs[4]  = '{"sh_x16",   1'b0, 1'b0,  1, 16'h4000, 16,    0, -256, 2};
      vecs[5]  = '{"sh_x32",   1'b0, 1'b0,  1, 16'h4000, 32, -256,    0, 2};
      vecs[6]  = '{"sh_x48",   1'b0, 1'b0,  1, 16'h4000, 48,    0,  256, 2};
      vecs[7]  = '{"sh_x8",    1'b0, 1'b0,  1, 16'h4000,  8,  181, -181, 2};
      vecs[8]  = '{"ish_x16",  1'b1, 1'b0,  1, 16'h4000, 16,    0,  256, 2};
      vecs[9]  = '{"ish_x8",   1'b1, 1'b0,  1, 16'h4000,  8,  181,  181, 2};
      vecs[10] = '{"iimp_x0",  1'b1, 1'b0,  0, 16'h4000,  0,  256,    0, 0};
      vecs[11] = '{"iimp_x37", 1'b1, 1'b0,  0, 16'h4000, 37,  256,    0, 0};
      vecs[12] = '{"imp_x21",  1'b0, 1'b0,  0, 16'h4000, 21,  256,    0, 0};

      rst   = 1'b1;
      start = 1'b0;
      drive(1'b0, 1'b0, -1, 0);
      repeat (2) @(negedge clk);
      check("rst_outputs", bad_words(0, 0), 0);
      check("rst_state", int'(state_dbg), 0);
      check("rst_stage", int'(stage_dbg), 0);
      rst = 1'b0;

      // Forward impulse: outputs must hold at zero through E1..E5
      @(negedge clk);
      drive(1'b0, 1'b0, 0, 16'h4000);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble();
      check("e0_state", int'(state_dbg), 1);
      for (int e = 1; e <= 5; e++) begin
         @(negedge clk);
         check($sformatf("hold_e%0d", e), bad_words(0, 0), 0);
         check($sformatf("stage_e%0d", e), int'(stage_dbg), e);
      end
      @(negedge clk);
      check("imp_all", bad_words(256, 0), 0);
      check("imp_idle", int'(state_dbg), 0);

      // Reset over nonzero outputs
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst2_outputs", bad_words(0, 0), 0);
      check("rst2_state", int'(state_dbg), 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run(vecs[i].inv, vecs[i].dc, vecs[i].pos, vecs[i].amp);
         check_tol({vecs[i].name, "_re"}, int'($signed(out_re[vecs[i].k])), vecs[i].exp_re, vecs[i].tol);
         check_tol({vecs[i].name, "_im"}, int'($signed(out_im[vecs[i].k])), vecs[i].exp_im, vecs[i].tol);
      end

      run(1'b1, 1'b0, 0, 16'h4000);
      check("iimp_all", bad_words(256, 0), 0);

      // Busy: a second request at E3 with other data is ignored
      @(negedge clk);
      drive(1'b0, 1'b1, -1, 16'h0200);
      start = 1'b1;
      exp_q.push_back({16'h0200, 16'h0000});
      exp_q.push_back({16'h0000, 16'h0000});
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      drive(1'b1, 1'b0, 0, 16'h4000);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         check($sformatf("busy_x%0d_re", k), int'(out_re[k]), int'(e[31:16]));
         check($sformatf("busy_x%0d_im", k), int'(out_im[k]), int'(e[15:0]));
      end
      @(negedge clk);
      check("busy_no_restart", int'(state_dbg), 0);

      // Back-to-back: start held high restarts on the first IDLE edge
      @(negedge clk);
      drive(1'b0, 1'b0, 0, 16'h4000);
      start = 1'b1;
      @(negedge clk);
      repeat (6) @(negedge clk);
      check("b2b_idle_e6", int'(state_dbg), 0);
      check("b2b_first", bad_words(256, 0), 0);
      @(negedge clk);
      start = 1'b0;
      check("b2b_restart", int'(state_dbg), 1);
      check("b2b_stage0", int'(stage_dbg), 0);
      repeat (6) @(negedge clk);
      check("b2b_second", bad_words(256, 0), 0);

      // Reset aborts a running transform; start with rst high is not honoured
      @(negedge clk);
      drive(1'b0, 1'b1, -1, 16'h0200);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_outputs", bad_words(0, 0), 0);
      check("abort_state", int'(state_dbg), 0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 0, 16'h4000);
      @(negedge clk);
      start = 1'b0;
      check("start_after_rst", int'(state_dbg), 1);
      repeat (6) @(negedge clk);
      check("after_rst_result", bad_words(256, 0), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
